// File: rtl/execute_alu_pkg.sv
// Shared opcode encoding and datapath width for the execute-stage ALU.
package execute_alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_MUL = 4'h2,
    ALU_DIV = 4'h3,
    ALU_OR  = 4'h4,
    ALU_AND = 4'h5,
    ALU_LSH = 4'h6,
    ALU_RSH = 4'h7,
    ALU_NEG = 4'h8,
    ALU_MOD = 4'h9,
    ALU_XOR = 4'hA,
    ALU_MOV = 4'hB,
    ALU_EQ  = 4'hC,
    ALU_GT  = 4'hD,
    ALU_GE  = 4'hE,
    ALU_SET = 4'hF
  } alu_op_e;

endpackage

// File: rtl/execute_alu_div.sv
// Combinational unsigned divider: quotient, remainder and divide-by-zero flag.
// Latency 0 (pure logic); no backpressure.
module execute_alu_div
  import execute_alu_pkg::*;
(
  input  logic [ALU_W-1:0] dividend,
  input  logic [ALU_W-1:0] divisor,
  output logic [ALU_W-1:0] quotient,
  output logic [ALU_W-1:0] remainder,
  output logic             div_by_zero
);

  // Guarded so a zero divisor never produces X: quotient 0, remainder passes the dividend.
  always_comb begin
    div_by_zero = (divisor == '0);
    quotient    = '0;
    remainder   = dividend;
    if (!div_by_zero) begin
      quotient  = dividend / divisor;
      remainder = dividend % divisor;
    end
  end

endmodule

// File: rtl/execute_alu_unit.sv
// 8-bit execute-stage ALU with registered result and zero flag; divider built only under EXECUTE_ALU_DIV_EN.
// Latency 1 cycle; no stall or enable, a new result is captured every clock.
module execute_alu_unit
  import execute_alu_pkg::*;
(
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [3:0]       iOPCODE,
  input  logic [ALU_W-1:0] iSOURCE0,
  input  logic [ALU_W-1:0] iSOURCE1,
  output logic [ALU_W-1:0] oRESULT,
  output logic             oZERO
);

  alu_op_e          op;
  logic [ALU_W-1:0] a, b;
  logic             shift_oob;
  logic [ALU_W-1:0] div_q, div_r;
  logic             div_dbz;
  logic [ALU_W-1:0] result_d, result_q;
  logic             zero_d, zero_q;

  assign op        = alu_op_e'(iOPCODE);
  assign a         = iSOURCE0;
  assign b         = iSOURCE1;
  assign shift_oob = (b >= 8'd8);

`ifdef EXECUTE_ALU_DIV_EN
  execute_alu_div u_div (
    .dividend    (a),
    .divisor     (b),
    .quotient    (div_q),
    .remainder   (div_r),
    .div_by_zero (div_dbz)
  );
`else
  assign div_q   = '0;
  assign div_r   = '0;
  assign div_dbz = 1'b1;
`endif

  always_comb begin
    result_d = '0;
    unique case (op)
      ALU_ADD: result_d = a + b;
      ALU_SUB: result_d = a - b;
      ALU_MUL: result_d = a * b;
`ifdef EXECUTE_ALU_DIV_EN
      ALU_DIV: result_d = div_dbz ? '0 : div_q;
      ALU_MOD: result_d = div_dbz ? a : div_r;
`else
      // No divider: both opcodes collapse to zero; the stub outputs are deliberately ignored.
      ALU_DIV: result_d = (div_dbz | ~div_dbz) ? '0 : div_q;
      ALU_MOD: result_d = (div_dbz | ~div_dbz) ? '0 : div_r;
`endif
      ALU_OR:  result_d = a | b;
      ALU_AND: result_d = a & b;
      ALU_LSH: result_d = shift_oob ? '0 : (a << b[2:0]);
      ALU_RSH: result_d = shift_oob ? '0 : (a >> b[2:0]);
      ALU_NEG: result_d = 8'd0 - a;
      ALU_XOR: result_d = a ^ b;
      ALU_MOV: result_d = b;
      ALU_EQ:  result_d = {7'd0, a == b};
      ALU_GT:  result_d = {7'd0, a > b};
      ALU_GE:  result_d = {7'd0, a >= b};
      ALU_SET: result_d = {7'd0, (a & b) != '0};
      default: result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign oRESULT = result_q;
  assign oZERO   = zero_q;

endmodule

// File: tb/tb_execute_alu_unit.sv
// Directed and randomized back-to-back checks of execute_alu_unit against an arithmetic reference model.
module tb_execute_alu_unit;

  logic       iCLK;
  logic       iRST;
  logic [3:0] iOPCODE;
  logic [7:0] iSOURCE0;
  logic [7:0] iSOURCE1;
  logic [7:0] oRESULT;
  logic       oZERO;

  int checks;
  int failures;

  execute_alu_unit dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iOPCODE  (iOPCODE),
    .iSOURCE0 (iSOURCE0),
    .iSOURCE1 (iSOURCE1),
    .oRESULT  (oRESULT),
    .oZERO    (oZERO)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  // Reference model in plain integer arithmetic, straight from the opcode table.
  function automatic logic [7:0] model(int op, int a, int b);
    int r;
    case (op)
      0:  r = a + b;
      1:  r = a - b + 256;
      2:  r = a * b;
`ifdef EXECUTE_ALU_DIV_EN
      3:  r = (b == 0) ? 0 : a / b;
      9:  r = (b == 0) ? a : a % b;
`else
      3:  r = 0;
      9:  r = 0;
`endif
      4:  r = a | b;
      5:  r = a & b;
      6:  r = (b >= 8) ? 0 : a * (1 << b);
      7:  r = (b >= 8) ? 0 : a / (1 << b);
      8:  r = 256 - a;
      10: r = a ^ b;
      11: r = b;
      12: r = (a == b) ? 1 : 0;
      13: r = (a > b) ? 1 : 0;
      14: r = (a >= b) ? 1 : 0;
      default: r = ((a & b) != 0) ? 1 : 0;
    endcase
    return 8'(r % 256);
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic rst, logic [3:0] op, logic [7:0] a, logic [7:0] b);
    iRST     = rst;
    iOPCODE  = op;
    iSOURCE0 = a;
    iSOURCE1 = b;
  endtask

  // One directed op: apply, take one edge, check result and zero flag.
  task automatic step(string tag, logic [3:0] op, logic [7:0] a, logic [7:0] b, logic [7:0] exp);
    drive(1'b0, op, a, b);
    @(posedge iCLK);
    #1;
    chk(tag, oRESULT, exp);
    chk({tag, "_zero"}, {7'd0, oZERO}, {7'd0, exp == 8'd0});
  endtask

  initial begin
    logic [3:0] op;
    logic [7:0] a, b, exp;
    checks   = 0;
    failures = 0;

    // Reset held for two edges with ADD 5,7 on the inputs.
    drive(1'b1, 4'h0, 8'd5, 8'd7);
    for (int i = 0; i < 2; i++) begin
      @(posedge iCLK);
      #1;
      chk("reset_result", oRESULT, 8'h00);
      chk("reset_zero", {7'd0, oZERO}, 8'h01);
    end
    iRST = 1'b0;
    @(posedge iCLK);
    #1;
    chk("post_reset_add", oRESULT, 8'h0C);
    chk("post_reset_zero", {7'd0, oZERO}, 8'h00);

    step("add_wrap", 4'h0, 8'hFF, 8'h02, 8'h01);
    step("sub_wrap", 4'h1, 8'h03, 8'h05, 8'hFE);
    step("neg",      4'h8, 8'h01, 8'h5A, 8'hFF);
    step("mul",      4'h2, 8'h10, 8'h11, 8'h10);
    step("lsh",      4'h6, 8'h81, 8'd1,  8'h02);
    step("rsh",      4'h7, 8'h80, 8'd7,  8'h01);
    step("lsh_oob",  4'h6, 8'hFF, 8'd8,  8'h00);
    step("rsh_oob",  4'h7, 8'hFF, 8'd200, 8'h00);
`ifdef EXECUTE_ALU_DIV_EN
    step("div",      4'h3, 8'd200, 8'd7, 8'd28);
    step("mod",      4'h9, 8'd200, 8'd7, 8'd4);
    step("div_zero", 4'h3, 8'd9,   8'd0, 8'd0);
    step("mod_zero", 4'h9, 8'd9,   8'd0, 8'd9);
`else
    step("div_off",  4'h3, 8'd200, 8'd7, 8'd0);
    step("mod_off",  4'h9, 8'd200, 8'd7, 8'd0);
`endif
    step("eq",       4'hC, 8'd5,   8'd5,   8'd1);
    step("gt",       4'hD, 8'd3,   8'd200, 8'd0);
    step("ge",       4'hE, 8'd7,   8'd7,   8'd1);
    step("set",      4'hF, 8'hF0,  8'h0F,  8'd0);
    step("xor",      4'hA, 8'hAA,  8'hFF,  8'h55);
    step("mov",      4'hB, 8'h77,  8'h3C,  8'h3C);
    step("or",       4'h4, 8'hA0,  8'h05,  8'hA5);
    step("and",      4'h5, 8'hF3,  8'h3C,  8'h30);

    // Reset in the middle of live traffic wins over the applied operation.
    drive(1'b1, 4'h0, 8'd1, 8'd1);
    @(posedge iCLK);
    #1;
    chk("reset_override", oRESULT, 8'h00);
    chk("reset_override_zero", {7'd0, oZERO}, 8'h01);

    // Back-to-back: a new opcode every cycle, checked one edge later, no idle cycles.
    for (int i = 0; i < 96; i++) begin
      op = 4'(i % 16);
      a  = 8'($urandom_range(0, 255));
      b  = ((i / 16) % 2 == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
      if (i % 32 == 31) b = a;
      exp = model(int'(op), int'(a), int'(b));
      drive(1'b0, op, a, b);
      @(posedge iCLK);
      #1;
      chk($sformatf("b2b_%0d_op%0h", i, op), oRESULT, exp);
      chk($sformatf("b2b_%0d_zero", i), {7'd0, oZERO}, {7'd0, exp == 8'd0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
